// File: rtl/thumb_wait_mem.sv
// Instruction and data memory for the pipelined Thumb core. Each port runs its own
// wait-state FSM and signals completion with a single-cycle ready pulse.
module thumb_wait_mem #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned HWORD_SIZE = 16,
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2,
  parameter logic [(HWORD_SIZE*(2**ADDR_BITS))-1:0] IMEM_INIT = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_instruction_n,
  input  logic [WORD_SIZE-1:0]  instruction_address,
  output logic [HWORD_SIZE-1:0] instruction,
  output logic                  instr_ready,
  input  logic                  read_data_n,
  input  logic                  write_data_n,
  input  logic [WORD_SIZE-1:0]  data_address,
  input  logic [WORD_SIZE-1:0]  wdata,
  output logic [WORD_SIZE-1:0]  rdata,
  output logic                  data_ready,
  output logic                  data_err
);

  localparam int unsigned DEPTH = 2**ADDR_BITS;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Instruction contents come from the IMEM_INIT image (read-only port).
  logic [HWORD_SIZE-1:0] irom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_irom
    assign irom[g] = IMEM_INIT[g*HWORD_SIZE +: HWORD_SIZE];
  end

  logic [WORD_SIZE-1:0] dmem [DEPTH];

  // Upper address bits alias onto the array index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instruction_address[WORD_SIZE-1:ADDR_BITS],
                              data_address[WORD_SIZE-1:ADDR_BITS]};

  state_t                i_state_q, i_state_d;
  logic [CW-1:0]         i_cnt_q, i_cnt_d;
  logic [ADDR_BITS-1:0]  i_idx_q, i_idx_d;
  logic [HWORD_SIZE-1:0] instruction_q, instruction_d;
  logic                  instr_ready_q, instr_ready_d;

  state_t                d_state_q, d_state_d;
  logic [CW-1:0]         d_cnt_q, d_cnt_d;
  logic [ADDR_BITS-1:0]  d_idx_q, d_idx_d;
  logic [WORD_SIZE-1:0]  d_wdata_q, d_wdata_d;
  logic                  d_write_q, d_write_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
  logic                  data_ready_q, data_ready_d;
  logic                  data_err_q, data_err_d;
  logic                  d_strobe_n;

  always_comb begin
    i_state_d     = i_state_q;
    i_cnt_d       = i_cnt_q;
    i_idx_d       = i_idx_q;
    instruction_d = instruction_q;
    instr_ready_d = 1'b0;
    case (i_state_q)
      S_IDLE: begin
        if (!read_instruction_n) begin
          i_idx_d = instruction_address[ADDR_BITS-1:0];
          i_cnt_d = CW'(READ_WAIT);
          if (READ_WAIT == 0) i_state_d = S_DONE;
          else                i_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (read_instruction_n) begin
          i_state_d = S_IDLE;
          i_cnt_d   = '0;
        end else begin
          i_cnt_d = i_cnt_q - CW'(1);
          if (i_cnt_q == CW'(1)) i_state_d = S_DONE;
        end
      end
      S_DONE: begin
        instruction_d = irom[i_idx_q];
        instr_ready_d = 1'b1;
        i_state_d     = S_IDLE;
      end
      default: i_state_d = S_IDLE;
    endcase
  end

  // Abort is judged against the strobe of the operation that was latched.
  assign d_strobe_n = d_write_q ? write_data_n : read_data_n;

  always_comb begin
    d_state_d    = d_state_q;
    d_cnt_d      = d_cnt_q;
    d_idx_d      = d_idx_q;
    d_wdata_d    = d_wdata_q;
    d_write_d    = d_write_q;
    rdata_d      = rdata_q;
    data_ready_d = 1'b0;
    data_err_d   = 1'b0;
    case (d_state_q)
      S_IDLE: begin
        if (!read_data_n && !write_data_n) begin
          data_err_d = 1'b1;
        end else if (!read_data_n || !write_data_n) begin
          d_idx_d   = data_address[ADDR_BITS-1:0];
          d_wdata_d = wdata;
          d_write_d = !write_data_n;
          d_cnt_d   = write_data_n ? CW'(READ_WAIT) : CW'(WRITE_WAIT);
          if (d_cnt_d == '0) d_state_d = S_DONE;
          else               d_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_strobe_n) begin
          d_state_d = S_IDLE;
          d_cnt_d   = '0;
        end else begin
          d_cnt_d = d_cnt_q - CW'(1);
          if (d_cnt_q == CW'(1)) d_state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!d_write_q) rdata_d = dmem[d_idx_q];
        data_ready_d = 1'b1;
        d_state_d    = S_IDLE;
      end
      default: d_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_state_q     <= S_IDLE;
      i_cnt_q       <= '0;
      i_idx_q       <= '0;
      instruction_q <= '0;
      instr_ready_q <= 1'b0;
      d_state_q     <= S_IDLE;
      d_cnt_q       <= '0;
      d_idx_q       <= '0;
      d_wdata_q     <= '0;
      d_write_q     <= 1'b0;
      rdata_q       <= '0;
      data_ready_q  <= 1'b0;
      data_err_q    <= 1'b0;
    end else begin
      i_state_q     <= i_state_d;
      i_cnt_q       <= i_cnt_d;
      i_idx_q       <= i_idx_d;
      instruction_q <= instruction_d;
      instr_ready_q <= instr_ready_d;
      d_state_q     <= d_state_d;
      d_cnt_q       <= d_cnt_d;
      d_idx_q       <= d_idx_d;
      d_wdata_q     <= d_wdata_d;
      d_write_q     <= d_write_d;
      rdata_q       <= rdata_d;
      data_ready_q  <= data_ready_d;
      data_err_q    <= data_err_d;
    end
  end

  // Array is never cleared; a write pending when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (!reset && d_state_q == S_DONE && d_write_q) dmem[d_idx_q] <= d_wdata_q;
  end

  assign instruction = instruction_q;
  assign instr_ready = instr_ready_q;
  assign rdata       = rdata_q;
  assign data_ready  = data_ready_q;
  assign data_err    = data_err_q;

endmodule

// File: tb/tb_thumb_wait_mem.sv
// Scoreboard bench for thumb_wait_mem: stimulus queues expected responses, monitors
// pop and compare whenever a ready/err pulse appears.
module tb_thumb_wait_mem;

  localparam logic [4095:0] IMEM0 = (4096'(16'h2909) << 96) | (4096'(16'h1234) << 112);
  localparam logic [4095:0] IMEM1 = 4096'(16'hA5C3) | (4096'(16'h0F0F) << 16);

  logic        clk = 1'b0;
  logic        reset;
  logic        rin0, rd0n, wr0n, ir0, dr0, de0;
  logic [31:0] ia0, da0, wd0, rdata0;
  logic [15:0] instr0;
  logic        rin1, rd1n, wr1n, ir1, dr1, de1;
  logic [31:0] ia1, da1, wd1, rdata1;
  logic [15:0] instr1;

  always #5 clk = ~clk;

  thumb_wait_mem #(.IMEM_INIT(IMEM0)) u0 (
    .clk(clk), .reset(reset),
    .read_instruction_n(rin0), .instruction_address(ia0),
    .instruction(instr0), .instr_ready(ir0),
    .read_data_n(rd0n), .write_data_n(wr0n), .data_address(da0), .wdata(wd0),
    .rdata(rdata0), .data_ready(dr0), .data_err(de0)
  );

  thumb_wait_mem #(.READ_WAIT(0), .IMEM_INIT(IMEM1)) u1 (
    .clk(clk), .reset(reset),
    .read_instruction_n(rin1), .instruction_address(ia1),
    .instruction(instr1), .instr_ready(ir1),
    .read_data_n(rd1n), .write_data_n(wr1n), .data_address(da1), .wdata(wd1),
    .rdata(rdata1), .data_ready(dr1), .data_err(de1)
  );

  typedef struct {
    logic [31:0] val;
    int          at;
    int          kind;   // 0 read, 1 write, 2 err
  } exp_t;

  exp_t q_i0[$];
  exp_t q_d0[$];
  exp_t q_i1[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors
  exp_t e0, e1, e2;
  always @(negedge clk) begin
    if (ir0 === 1'b1) begin
      if (q_i0.size() == 0) chk("i0 unexpected ready", 32'(ir0), 32'd0);
      else begin
        e0 = q_i0.pop_front();
        chk("i0 instruction", 32'(instr0), e0.val);
        chk("i0 ready cycle", 32'(cyc), 32'(e0.at));
      end
    end
    if (dr0 === 1'b1 || de0 === 1'b1) begin
      if (q_d0.size() == 0) chk("d0 unexpected pulse", 32'({dr0, de0}), 32'd0);
      else begin
        e1 = q_d0.pop_front();
        chk("d0 ready/err", 32'({dr0, de0}), (e1.kind == 2) ? 32'd1 : 32'd2);
        chk("d0 pulse cycle", 32'(cyc), 32'(e1.at));
        if (e1.kind == 0) chk("d0 rdata", rdata0, e1.val);
      end
    end
    if (ir1 === 1'b1) begin
      if (q_i1.size() == 0) chk("i1 unexpected ready", 32'(ir1), 32'd0);
      else begin
        e2 = q_i1.pop_front();
        chk("i1 instruction", 32'(instr1), e2.val);
        chk("i1 ready cycle", 32'(cyc), 32'(e2.at));
      end
    end
    if (dr1 === 1'b1 || de1 === 1'b1) chk("d1 spurious pulse", 32'({dr1, de1}), 32'd0);
  end

  task automatic wait_ready(input int which);
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      case (which)
        0:       ok = (ir0 === 1'b1);
        1:       ok = (dr0 === 1'b1) || (de0 === 1'b1);
        default: ok = (ir1 === 1'b1);
      endcase
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout waiting on port %0d: got no pulse expected pulse within 40 cycles", which);
    end
  endtask

  task automatic fetch0(input logic [31:0] addr, input logic [15:0] exp);
    @(negedge clk);
    ia0  = addr;
    rin0 = 1'b0;
    q_i0.push_back('{32'(exp), cyc + 4, 0});
    wait_ready(0);
    rin0 = 1'b1;
  endtask

  task automatic dwrite0(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    da0  = addr;
    wd0  = data;
    wr0n = 1'b0;
    q_d0.push_back('{32'd0, cyc + 4, 1});
    wait_ready(1);
    wr0n = 1'b1;
  endtask

  task automatic dread0(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    da0  = addr;
    rd0n = 1'b0;
    q_d0.push_back('{exp, cyc + 4, 0});
    wait_ready(1);
    rd0n = 1'b1;
  endtask

  int base;

  initial begin
    reset = 1'b1;
    rin0 = 1'b0; rd0n = 1'b0; wr0n = 1'b0; ia0 = 32'd6; da0 = 32'h24; wd0 = 32'h0;
    rin1 = 1'b0; rd1n = 1'b0; wr1n = 1'b0; ia1 = 32'd0; da1 = 32'h0;  wd1 = 32'h0;

    // Reset held two cycles with strobes low
    repeat (2) begin
      @(negedge clk);
      chk("rst instruction0", 32'(instr0), 32'd0);
      chk("rst instr_ready0", 32'(ir0), 32'd0);
      chk("rst rdata0", rdata0, 32'd0);
      chk("rst data_ready0", 32'(dr0), 32'd0);
      chk("rst data_err0", 32'(de0), 32'd0);
      chk("rst instruction1", 32'(instr1), 32'd0);
      chk("rst instr_ready1", 32'(ir1), 32'd0);
      chk("rst rdata1", rdata1, 32'd0);
      chk("rst data_ready1", 32'(dr1), 32'd0);
      chk("rst data_err1", 32'(de1), 32'd0);
    end
    reset = 1'b0;
    rin0 = 1'b1; rd0n = 1'b1; wr0n = 1'b1;
    rin1 = 1'b1; rd1n = 1'b1; wr1n = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch with two wait states, plus index wrap on 0x106
    fetch0(32'd6, 16'h2909);
    fetch0(32'd7, 16'h1234);
    fetch0(32'h106, 16'h2909);

    // Write then read back
    dwrite0(32'h24, 32'h24);
    dread0(32'h24, 32'h00000024);

    // Write aborted after one wait cycle
    @(negedge clk);
    da0 = 32'h24; wd0 = 32'h55; wr0n = 1'b0;
    repeat (2) @(negedge clk);
    wr0n = 1'b1;
    repeat (5) @(negedge clk);
    dread0(32'h24, 32'h00000024);

    // Both data strobes low: error pulse, no access
    @(negedge clk);
    da0 = 32'h24; wd0 = 32'hDEADBEEF; rd0n = 1'b0; wr0n = 1'b0;
    q_d0.push_back('{32'd0, cyc + 1, 2});
    @(negedge clk);
    rd0n = 1'b1; wr0n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rdata held after err", rdata0, 32'h00000024);
    dread0(32'h24, 32'h00000024);

    // Data aliasing and both ports active together
    dwrite0(32'h10, 32'hCAFE0001);
    fork
      fetch0(32'd7, 16'h1234);
      dread0(32'h110, 32'hCAFE0001);
    join

    // Zero-wait back-to-back fetches at 0x0 and 0x100
    @(negedge clk);
    ia1  = 32'h0;
    rin1 = 1'b0;
    base = cyc;
    q_i1.push_back('{32'h0000A5C3, base + 2, 0});
    q_i1.push_back('{32'h0000A5C3, base + 4, 0});
    wait_ready(2);
    ia1 = 32'h100;
    wait_ready(2);
    rin1 = 1'b1;

    repeat (5) @(negedge clk);
    chk("i0 queue drained", 32'(q_i0.size()), 32'd0);
    chk("d0 queue drained", 32'(q_d0.size()), 32'd0);
    chk("i1 queue drained", 32'(q_i1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
